// File: rtl/ase_emul_ccip_arb_pkg.sv
// Shared types and constants for the ASE c0 read-channel port multiplexer.
// Headers are a reduced CCI-P c0 layout; mdata high bits carry the port tag.
package ase_emul_ccip_arb_pkg;

  localparam int TAG_MSB             = 15;
  localparam int MAX_AFU_PORTS       = 8;
  localparam int DEF_FIFO_DEPTH      = 16;
  localparam int DEF_ALM_FULL_THRESH = 8;
  localparam int CL_DATA_W           = 512;

  // Wide enough for any port index up to MAX_AFU_PORTS-1
  typedef logic [2:0] t_port_idx;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [1:0]  vc_sel;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic               valid;
    t_ccip_c0_ReqMemHdr hdr;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        hit_miss;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr   hdr;
    logic [CL_DATA_W-1:0] data;
    logic                 rspValid;
    logic                 mmioRdValid;
    logic                 mmioWrValid;
  } t_if_ccip_c0_Rx;

endpackage

// File: rtl/ase_emul_ccip_c0_req_fifo.sv
// Per-port c0 request header FIFO with registered almost-full.
// Enqueue into a full FIFO is dropped; the head is read combinationally.
module ase_emul_ccip_c0_req_fifo
  import ase_emul_ccip_arb_pkg::*;
#(
  parameter int DEPTH           = DEF_FIFO_DEPTH,
  parameter int ALM_FULL_THRESH = DEF_ALM_FULL_THRESH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_enq_en,
  input  t_ccip_c0_ReqMemHdr i_enq_hdr,
  input  logic               i_deq_en,
  output logic               o_notEmpty,
  output t_ccip_c0_ReqMemHdr o_first,
  output logic               o_almFull
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  t_ccip_c0_ReqMemHdr r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_alm;
  logic               w_full, w_wr, w_rd;

  assign w_full = (r_cnt == CNT_W'(DEPTH));
  assign w_wr   = i_enq_en && !w_full;
  assign w_rd   = i_deq_en && (r_cnt != '0);

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_wr && !w_rd)      w_cnt_next = r_cnt + CNT_W'(1);
    else if (!w_wr && w_rd) w_cnt_next = r_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_alm    <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_cnt <= w_cnt_next;
      // free entries <= threshold, evaluated on post-update occupancy
      r_alm <= (int'(w_cnt_next) >= DEPTH - ALM_FULL_THRESH);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_enq_hdr;
  end

  assign o_notEmpty = (r_cnt != '0);
  assign o_first    = r_mem[r_rd_ptr];
  assign o_almFull  = r_alm;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(i_enq_en && w_full));

endmodule

// File: rtl/ase_emul_ccip_c0_read_arb.sv
// c0 read-channel mux: round-robin merge of per-port requests onto the FIU,
// port-index tag in mdata, and tag-steered return of read responses.
module ase_emul_ccip_c0_read_arb
  import ase_emul_ccip_arb_pkg::*;
#(
  parameter int NUM_AFU_PORTS   = 2,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int ALM_FULL_THRESH = DEF_ALM_FULL_THRESH
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  t_if_ccip_c0_Tx [NUM_AFU_PORTS-1:0] afu_c0Tx,
  output logic           [NUM_AFU_PORTS-1:0] afu_c0TxAlmFull,
  output t_if_ccip_c0_Rx [NUM_AFU_PORTS-1:0] afu_c0Rx,
  output t_if_ccip_c0_Tx                     fiu_c0Tx,
  input  logic                               fiu_c0TxAlmFull,
  input  t_if_ccip_c0_Rx                     fiu_c0Rx,
  output logic [15:0]                        unroutable_cnt
);

  localparam int IDX_W = idx_w(NUM_AFU_PORTS);

  logic               [NUM_AFU_PORTS-1:0] w_nempty;
  logic               [NUM_AFU_PORTS-1:0] w_deq;
  t_ccip_c0_ReqMemHdr [NUM_AFU_PORTS-1:0] w_first;

  logic               w_sel_vld, w_gnt;
  t_port_idx          w_sel_idx;
  t_ccip_c0_ReqMemHdr w_gnt_hdr;
  t_port_idx          r_rr;
  t_if_ccip_c0_Tx     r_fiu_tx;

  for (genvar p = 0; p < NUM_AFU_PORTS; p++) begin : g_port
    assign w_deq[p] = w_gnt && (w_sel_idx == t_port_idx'(p));

    ase_emul_ccip_c0_req_fifo #(
      .DEPTH           (FIFO_DEPTH),
      .ALM_FULL_THRESH (ALM_FULL_THRESH)
    ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_enq_en   (afu_c0Tx[p].valid),
      .i_enq_hdr  (afu_c0Tx[p].hdr),
      .i_deq_en   (w_deq[p]),
      .o_notEmpty (w_nempty[p]),
      .o_first    (w_first[p]),
      .o_almFull  (afu_c0TxAlmFull[p])
    );

    // The tag field belongs to this block; AFUs must leave it clear
    a_tag_clear: assert property (@(posedge clk) disable iff (!reset_n)
      afu_c0Tx[p].valid |-> (afu_c0Tx[p].hdr.mdata[TAG_MSB -: IDX_W] == '0));
  end

  // Round-robin scan: first non-empty port at or after the pointer
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    for (int i = 0; i < NUM_AFU_PORTS; i++) begin
      for (int p = 0; p < NUM_AFU_PORTS; p++) begin
        if (!w_sel_vld && w_nempty[p] && (p == (int'(r_rr) + i) % NUM_AFU_PORTS)) begin
          w_sel_vld = 1'b1;
          w_sel_idx = t_port_idx'(p);
        end
      end
    end
  end

  assign w_gnt = w_sel_vld && !fiu_c0TxAlmFull;

  always_comb begin
    w_gnt_hdr = '0;
    for (int p = 0; p < NUM_AFU_PORTS; p++) begin
      if (w_sel_idx == t_port_idx'(p)) w_gnt_hdr = w_first[p];
    end
    w_gnt_hdr.mdata[TAG_MSB -: IDX_W] = w_sel_idx[IDX_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fiu_tx <= '0;
      r_rr     <= '0;
    end else begin
      r_fiu_tx.valid <= w_gnt;
      if (w_gnt) begin
        r_fiu_tx.hdr <= w_gnt_hdr;
        r_rr <= (w_sel_idx == t_port_idx'(NUM_AFU_PORTS - 1)) ? '0 : w_sel_idx + t_port_idx'(1);
      end
    end
  end

  assign fiu_c0Tx = r_fiu_tx;

  logic [IDX_W-1:0]         w_rsp_tag;
  t_ccip_c0_RspMemHdr       w_rsp_hdr;
  logic [NUM_AFU_PORTS-1:0] w_rsp_route;
  logic                     w_unroutable;

  logic [NUM_AFU_PORTS-1:0] r_rsp_vld;
  logic                     r_mmio_rd, r_mmio_wr;
  t_ccip_c0_RspMemHdr       r_rx_hdr;
  logic [CL_DATA_W-1:0]     r_rx_data;
  logic [15:0]              r_unroutable_cnt;

  always_comb begin
    w_rsp_tag = fiu_c0Rx.hdr.mdata[TAG_MSB -: IDX_W];
    w_rsp_hdr = fiu_c0Rx.hdr;
    if (fiu_c0Rx.rspValid) w_rsp_hdr.mdata[TAG_MSB -: IDX_W] = '0;
    w_unroutable = fiu_c0Rx.rspValid && (int'(w_rsp_tag) >= NUM_AFU_PORTS);
    for (int p = 0; p < NUM_AFU_PORTS; p++) begin
      w_rsp_route[p] = fiu_c0Rx.rspValid && (w_rsp_tag == IDX_W'(p));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_vld        <= '0;
      r_mmio_rd        <= 1'b0;
      r_mmio_wr        <= 1'b0;
      r_rx_hdr         <= '0;
      r_unroutable_cnt <= '0;
    end else begin
      r_rsp_vld <= w_rsp_route;
      r_mmio_rd <= fiu_c0Rx.mmioRdValid;
      r_mmio_wr <= fiu_c0Rx.mmioWrValid;
      r_rx_hdr  <= w_rsp_hdr;
      if (w_unroutable && (r_unroutable_cnt != 16'hFFFF))
        r_unroutable_cnt <= r_unroutable_cnt + 16'd1;
    end
  end

  // Payload is broadcast; only the valid bits select the receiver
  always_ff @(posedge clk) begin
    r_rx_data <= fiu_c0Rx.data;
  end

  always_comb begin
    afu_c0Rx = '0;
    for (int p = 0; p < NUM_AFU_PORTS; p++) begin
      afu_c0Rx[p].hdr         = r_rx_hdr;
      afu_c0Rx[p].data        = r_rx_data;
      afu_c0Rx[p].rspValid    = r_rsp_vld[p];
      afu_c0Rx[p].mmioRdValid = (p == 0) && r_mmio_rd;
      afu_c0Rx[p].mmioWrValid = (p == 0) && r_mmio_wr;
    end
  end

  assign unroutable_cnt = r_unroutable_cnt;

endmodule

// File: tb/tb_ase_emul_ccip_c0_read_arb.sv
// Bench for the c0 read mux: N=2, N=3 and N=4 instances share clock and reset;
// expectations come from arbitration/routing rules modelled in plain arithmetic.
module tb_ase_emul_ccip_c0_read_arb;
  import ase_emul_ccip_arb_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  t_if_ccip_c0_Tx [1:0] tx2;  logic [1:0] af2;  t_if_ccip_c0_Rx [1:0] rx2;
  t_if_ccip_c0_Tx ftx2;  logic fal2;  t_if_ccip_c0_Rx frx2;  logic [15:0] cnt2;
  t_if_ccip_c0_Tx [2:0] tx3;  logic [2:0] af3;  t_if_ccip_c0_Rx [2:0] rx3;
  t_if_ccip_c0_Tx ftx3;  logic fal3;  t_if_ccip_c0_Rx frx3;  logic [15:0] cnt3;
  t_if_ccip_c0_Tx [3:0] tx4;  logic [3:0] af4;  t_if_ccip_c0_Rx [3:0] rx4;
  t_if_ccip_c0_Tx ftx4;  logic fal4;  t_if_ccip_c0_Rx frx4;  logic [15:0] cnt4;

  ase_emul_ccip_c0_read_arb #(.NUM_AFU_PORTS(2)) u2 (
    .clk(clk), .reset_n(reset_n), .afu_c0Tx(tx2), .afu_c0TxAlmFull(af2), .afu_c0Rx(rx2),
    .fiu_c0Tx(ftx2), .fiu_c0TxAlmFull(fal2), .fiu_c0Rx(frx2), .unroutable_cnt(cnt2));
  ase_emul_ccip_c0_read_arb #(.NUM_AFU_PORTS(3)) u3 (
    .clk(clk), .reset_n(reset_n), .afu_c0Tx(tx3), .afu_c0TxAlmFull(af3), .afu_c0Rx(rx3),
    .fiu_c0Tx(ftx3), .fiu_c0TxAlmFull(fal3), .fiu_c0Rx(frx3), .unroutable_cnt(cnt3));
  ase_emul_ccip_c0_read_arb #(.NUM_AFU_PORTS(4)) u4 (
    .clk(clk), .reset_n(reset_n), .afu_c0Tx(tx4), .afu_c0TxAlmFull(af4), .afu_c0Rx(rx4),
    .fiu_c0Tx(ftx4), .fiu_c0TxAlmFull(fal4), .fiu_c0Rx(frx4), .unroutable_cnt(cnt4));

  int errors = 0;
  int checks = 0;
  int rr4 = 0;    // model of u4's round-robin start port
  int exp3 = 0;   // model of u3's unroutable count

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic t_ccip_c0_ReqMemHdr rnd_hdr();
    t_ccip_c0_ReqMemHdr h;
    h.vc_sel   = 2'($urandom);
    h.cl_len   = 2'($urandom);
    h.req_type = 4'($urandom);
    h.address  = {10'($urandom), $urandom};
    h.mdata    = 16'($urandom) & 16'h1FFF;
    return h;
  endfunction

  function automatic logic [3:0] vec4(input int kind);
    logic [3:0] v;
    for (int p = 0; p < 4; p++)
      v[p] = (kind == 0) ? rx4[p].rspValid : (kind == 1) ? rx4[p].mmioRdValid : rx4[p].mmioWrValid;
    return v;
  endfunction

  function automatic logic [2:0] vec3();
    logic [2:0] v;
    for (int p = 0; p < 3; p++) v[p] = rx3[p].rspValid;
    return v;
  endfunction

  task automatic test_reset();
    t_ccip_c0_ReqMemHdr h;
    logic [15:0] outs;
    reset_n = 1'b0;
    tx2[0].valid = 1'b1; tx2[0].hdr = rnd_hdr();
    tx2[1].valid = 1'b1; tx2[1].hdr = rnd_hdr();
    tx4[2].valid = 1'b1; tx4[2].hdr = rnd_hdr();
    repeat (3) tick();
    outs = {ftx2.valid, af2, rx2[0].rspValid, rx2[0].mmioRdValid, rx2[0].mmioWrValid,
            rx2[1].rspValid, rx2[1].mmioRdValid, rx2[1].mmioWrValid, ftx4.valid, af4[2], vec4(0)};
    checks++;
    if (outs !== 16'h0 || cnt2 !== 16'h0) begin
      errors++; $display("FAIL reset_outs got=%h cnt=%h required=0", outs, cnt2);
    end
    tx2 = '0; tx4 = '0;
    reset_n = 1'b1;
    rr4 = 0; exp3 = 0;
    repeat (2) tick();
    h = rnd_hdr(); h.mdata = 16'h0042;
    tx2[1].valid = 1'b1; tx2[1].hdr = h;
    tick();
    tx2[1].valid = 1'b0;
    checks++;
    if (ftx2.valid !== 1'b0) begin
      errors++; $display("FAIL reset_lat1 got valid=%b required=0", ftx2.valid);
    end
    tick();
    h.mdata = 16'h8042;
    checks++;
    if (ftx2.valid !== 1'b1 || ftx2.hdr !== h) begin
      errors++; $display("FAIL reset_first_req got v=%b mdata=%h required v=1 mdata=%h", ftx2.valid, ftx2.hdr.mdata, h.mdata);
    end
    tick();
    checks++;
    if (ftx2.valid !== 1'b0) begin
      errors++; $display("FAIL reset_single_only got valid=%b required=0", ftx2.valid);
    end
  endtask

  task automatic test_fairness();
    t_ccip_c0_ReqMemHdr h [4][6];
    t_ccip_c0_ReqMemHdr exp_h;
    int k, p;
    for (int q = 0; q < 4; q++) for (int c = 0; c < 6; c++) h[q][c] = rnd_hdr();
    for (int cyc = 0; cyc < 28; cyc++) begin
      checks++;
      if (cyc >= 2 && cyc < 26) begin
        k = cyc - 2;
        p = (rr4 + k) % 4;
        exp_h = h[p][k / 4];
        exp_h.mdata[15:14] = 2'(p);
        if (ftx4.valid !== 1'b1 || ftx4.hdr !== exp_h) begin
          errors++; $display("FAIL fair_grant k=%0d got v=%b mdata=%h addr=%h required mdata=%h addr=%h",
                             k, ftx4.valid, ftx4.hdr.mdata, ftx4.hdr.address, exp_h.mdata, exp_h.address);
        end
      end else if (ftx4.valid !== 1'b0) begin
        errors++; $display("FAIL fair_idle cyc=%0d got valid=%b required=0", cyc, ftx4.valid);
      end
      for (int q = 0; q < 4; q++) begin
        tx4[q].valid = (cyc < 6);
        if (cyc < 6) tx4[q].hdr = h[q][cyc];
        else tx4[q].hdr = '0;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    t_ccip_c0_ReqMemHdr h [8];
    t_ccip_c0_ReqMemHdr exp_h;
    fal4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      h[k] = rnd_hdr();
      tx4[0].valid = 1'b1; tx4[0].hdr = h[k];
      tick();
      tx4[0].valid = 1'b0;
      checks++;
      if (af4[0] !== (k + 1 >= 8) || ftx4.valid !== 1'b0) begin
        errors++; $display("FAIL bp_fill n=%0d got alm=%b fv=%b required alm=%b fv=0", k + 1, af4[0], ftx4.valid, (k + 1 >= 8));
      end
    end
    repeat (3) begin
      tick();
      checks++;
      if (af4[0] !== 1'b1 || ftx4.valid !== 1'b0) begin
        errors++; $display("FAIL bp_hold got alm=%b fv=%b required alm=1 fv=0", af4[0], ftx4.valid);
      end
    end
    fal4 = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      exp_h = h[k];
      checks++;
      if (ftx4.valid !== 1'b1 || ftx4.hdr !== exp_h) begin
        errors++; $display("FAIL bp_drain k=%0d got v=%b mdata=%h required v=1 mdata=%h", k, ftx4.valid, ftx4.hdr.mdata, exp_h.mdata);
      end
      tick();
    end
    rr4 = 1;
    checks++;
    if (ftx4.valid !== 1'b0 || af4[0] !== 1'b0) begin
      errors++; $display("FAIL bp_empty got fv=%b alm=%b required 0 0", ftx4.valid, af4[0]);
    end
  endtask

  task automatic test_rx_routing();
    int t4, t3;
    logic [13:0] low4, low3;
    logic [1:0] cl;
    logic [3:0] ev4;
    logic [2:0] ev3;
    frx4 = '0; frx3 = '0;
    frx4.rspValid = 1'b1; frx4.hdr.mdata = 16'h4007; frx4.hdr.cl_num = 2'd2;
    frx3.rspValid = 1'b1; frx3.hdr.mdata = 16'hC011;
    exp3++;
    tick();
    checks++;
    if (vec4(0) !== 4'b0010 || rx4[1].hdr.mdata !== 16'h0007 || rx4[1].hdr.cl_num !== 2'd2) begin
      errors++; $display("FAIL rx_direct4 got vec=%b mdata=%h cl=%0d required vec=0010 mdata=0007 cl=2",
                         vec4(0), rx4[1].hdr.mdata, rx4[1].hdr.cl_num);
    end
    checks++;
    if (vec3() !== 3'b000 || cnt3 !== 16'(exp3)) begin
      errors++; $display("FAIL rx_unroutable3 got vec=%b cnt=%0d required vec=000 cnt=%0d", vec3(), cnt3, exp3);
    end
    for (int i = 0; i < 16; i++) begin
      t4 = $urandom_range(0, 3); low4 = 14'($urandom); cl = 2'($urandom);
      t3 = $urandom_range(0, 3); low3 = 14'($urandom);
      frx4.hdr.mdata = {2'(t4), low4}; frx4.hdr.cl_num = cl; frx4.hdr.resp_type = 4'($urandom);
      frx3.hdr.mdata = {2'(t3), low3};
      if (t3 == 3) exp3++;
      tick();
      ev4 = 4'b0001 << t4;
      ev3 = (t3 < 3) ? (3'b001 << t3) : 3'b000;
      checks++;
      if (vec4(0) !== ev4 || rx4[t4].hdr.mdata !== {2'b00, low4} || rx4[t4].hdr.cl_num !== cl) begin
        errors++; $display("FAIL rx_rand4 i=%0d got vec=%b mdata=%h cl=%0d required vec=%b mdata=%h cl=%0d",
                           i, vec4(0), rx4[t4].hdr.mdata, rx4[t4].hdr.cl_num, ev4, {2'b00, low4}, cl);
      end
      checks++;
      if (vec3() !== ev3 || cnt3 !== 16'(exp3)) begin
        errors++; $display("FAIL rx_rand3 i=%0d got vec=%b cnt=%0d required vec=%b cnt=%0d", i, vec3(), cnt3, ev3, exp3);
      end
    end
    frx4 = '0; frx3 = '0;
    tick();
    checks++;
    if (vec4(0) !== 4'b0 || vec3() !== 3'b0 || cnt3 !== 16'(exp3)) begin
      errors++; $display("FAIL rx_idle got v4=%b v3=%b cnt=%0d required 0 0 %0d", vec4(0), vec3(), cnt3, exp3);
    end
  endtask

  task automatic test_mmio_rsp();
    logic [CL_DATA_W-1:0] d;
    for (int w = 0; w < CL_DATA_W / 32; w++) d[w*32 +: 32] = $urandom;
    frx4 = '0;
    frx4.rspValid = 1'b1; frx4.mmioRdValid = 1'b1;
    frx4.hdr.mdata = 16'h8123; frx4.data = d;
    tick();
    frx4 = '0;
    checks++;
    if (vec4(0) !== 4'b0100 || vec4(1) !== 4'b0001 || vec4(2) !== 4'b0000) begin
      errors++; $display("FAIL mmio_rd_rsp got rsp=%b rd=%b wr=%b required 0100 0001 0000", vec4(0), vec4(1), vec4(2));
    end
    checks++;
    if (rx4[2].data !== d || rx4[0].data !== d || rx4[2].hdr.mdata !== 16'h0123) begin
      errors++; $display("FAIL mmio_rsp_payload got mdata=%h data_lo=%h required mdata=0123 data_lo=%h",
                         rx4[2].hdr.mdata, rx4[2].data[31:0], d[31:0]);
    end
    frx4.rspValid = 1'b1; frx4.mmioWrValid = 1'b1; frx4.hdr.mdata = 16'h0055;
    tick();
    frx4 = '0;
    checks++;
    if (vec4(0) !== 4'b0001 || vec4(2) !== 4'b0001 || vec4(1) !== 4'b0000) begin
      errors++; $display("FAIL mmio_wr_rsp got rsp=%b rd=%b wr=%b required 0001 0000 0001", vec4(0), vec4(1), vec4(2));
    end
    tick();
  endtask

  task automatic test_midop_reset();
    t_ccip_c0_ReqMemHdr h [5];
    t_ccip_c0_ReqMemHdr exp_h;
    fal4 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      h[k] = rnd_hdr();
      tx4[1].valid = 1'b1; tx4[1].hdr = h[k];
      tick();
    end
    tx4[1].valid = 1'b0;
    fal4 = 1'b0;
    tick();
    exp_h = h[0]; exp_h.mdata[15:14] = 2'd1;
    checks++;
    if (ftx4.valid !== 1'b1 || ftx4.hdr !== exp_h) begin
      errors++; $display("FAIL midop_pre got v=%b mdata=%h required v=1 mdata=%h", ftx4.valid, ftx4.hdr.mdata, exp_h.mdata);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ftx4.valid !== 1'b0 || af4 !== 4'b0 || cnt3 !== 16'h0) begin
      errors++; $display("FAIL midop_async got fv=%b alm=%b cnt3=%0d required 0 0 0", ftx4.valid, af4, cnt3);
    end
    tick();
    reset_n = 1'b1;
    rr4 = 0; exp3 = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (ftx4.valid !== 1'b0) begin
        errors++; $display("FAIL midop_stale c=%0d got valid=%b required=0", c, ftx4.valid);
      end
    end
    exp_h = rnd_hdr();
    tx4[3].valid = 1'b1; tx4[3].hdr = exp_h;
    tick();
    tx4[3].valid = 1'b0;
    tick();
    exp_h.mdata[15:14] = 2'd3;
    checks++;
    if (ftx4.valid !== 1'b1 || ftx4.hdr !== exp_h) begin
      errors++; $display("FAIL midop_after got v=%b mdata=%h required v=1 mdata=%h", ftx4.valid, ftx4.hdr.mdata, exp_h.mdata);
    end
    tick();
  endtask

  initial begin
    tx2 = '0; tx3 = '0; tx4 = '0;
    frx2 = '0; frx3 = '0; frx4 = '0;
    fal2 = 1'b0; fal3 = 1'b0; fal4 = 1'b0;
    test_reset();
    test_fairness();
    test_backpressure();
    test_rx_routing();
    test_mmio_rsp();
    test_midop_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
